// File: rtl/cpu_mmu_ppn_seq.sv
// Sequences one microcode PPN command into timed transceiver enables and a RAM write strobe.
// Latency: SETUP + DRIVE_CYCLES + (writes only: WR_CYCLES + HOLD) + FIN cycles; done pulses in FIN.
// Backpressure: cmd_valid is sampled only in IDLE; requests arriving while busy are dropped, not queued.
//
// Ports:
//   sysclk, sys_rst_n        clock, asynchronous active-low reset
//   cmd_valid, cmd[1:0]      command request (00 read, 01 write both, 10 ring upper, 11 lower only)
//   PPN_25_10_IN[15:0]       PPN bus from page-table RAM, captured at the end of a read's DRIVE phase
//   EIPU_n, EIPL_n, EIPUR_n  transceiver enables (active low)
//   ESTOF_n                  transceiver direction (1 = PPN->IDB)
//   WPT_n                    page-table RAM write strobe (active low)
//   busy, done, ppn_hold     handshake and last captured PPN
module cpu_mmu_ppn_seq #(
  parameter int unsigned DRIVE_CYCLES = 1,
  parameter int unsigned WR_CYCLES    = 2
) (
  input  logic        sysclk,
  input  logic        sys_rst_n,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd,
  input  logic [15:0] PPN_25_10_IN,
  output logic        EIPU_n,
  output logic        EIPL_n,
  output logic        EIPUR_n,
  output logic        ESTOF_n,
  output logic        WPT_n,
  output logic        busy,
  output logic        done,
  output logic [15:0] ppn_hold
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_DRIVE = 3'd2,
    S_WSTB  = 3'd3,
    S_HOLD  = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  localparam logic [1:0] CMD_RD   = 2'b00;
  localparam logic [1:0] CMD_RING = 2'b10;
  localparam logic [1:0] CMD_LOW  = 2'b11;

  // Down-counters hold (cycles - 1) so the phase ends when the count reaches zero.
  localparam logic [3:0] DRV_LD = 4'(DRIVE_CYCLES - 1);
  localparam logic [3:0] WR_LD  = 4'(WR_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  cmd_r_q, cmd_r_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] ppn_hold_q, ppn_hold_d;
  logic        eipu_n_q, eipu_n_d;
  logic        eipl_n_q, eipl_n_d;
  logic        eipur_n_q, eipur_n_d;
  logic        estof_n_q, estof_n_d;
  logic        wpt_n_q, wpt_n_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // Next-state and counter logic.
  always_comb begin
    state_d    = state_q;
    cmd_r_d    = cmd_r_q;
    cnt_d      = cnt_q;
    ppn_hold_d = ppn_hold_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          cmd_r_d = cmd;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        state_d = S_DRIVE;
        cnt_d   = DRV_LD;
      end
      S_DRIVE: begin
        if (cnt_q == 4'd0) begin
          if (cmd_r_q == CMD_RD) begin
            // Capture on the last DRIVE edge, while the transceivers still drive the bus.
            ppn_hold_d = PPN_25_10_IN;
            state_d    = S_FIN;
          end else begin
            state_d = S_WSTB;
            cnt_d   = WR_LD;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WSTB: begin
        if (cnt_q == 4'd0) begin
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_HOLD:  state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so each output
  // reflects the state that is current in the same cycle, without an input-to-output path.
  always_comb begin
    eipu_n_d  = 1'b1;
    eipl_n_d  = 1'b1;
    eipur_n_d = 1'b1;
    estof_n_d = 1'b1;
    wpt_n_d   = 1'b1;
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_FIN);

    // Direction is set from SETUP onwards, one cycle ahead of any enable.
    if (state_d == S_SETUP || state_d == S_DRIVE || state_d == S_WSTB || state_d == S_HOLD) begin
      estof_n_d = (cmd_r_d == CMD_RD);
    end

    // Enables stay asserted through the strobe and the hold cycle after it.
    if (state_d == S_DRIVE || state_d == S_WSTB || state_d == S_HOLD) begin
      eipu_n_d  = (cmd_r_d == CMD_LOW);
      eipl_n_d  = (cmd_r_d == CMD_RING);
      eipur_n_d = (cmd_r_d != CMD_RING);
    end

    if (state_d == S_WSTB) begin
      wpt_n_d = 1'b0;
    end
  end

  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= S_IDLE;
      cmd_r_q    <= 2'b00;
      cnt_q      <= 4'd0;
      ppn_hold_q <= 16'h0000;
      eipu_n_q   <= 1'b1;
      eipl_n_q   <= 1'b1;
      eipur_n_q  <= 1'b1;
      estof_n_q  <= 1'b1;
      wpt_n_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_r_q    <= cmd_r_d;
      cnt_q      <= cnt_d;
      ppn_hold_q <= ppn_hold_d;
      eipu_n_q   <= eipu_n_d;
      eipl_n_q   <= eipl_n_d;
      eipur_n_q  <= eipur_n_d;
      estof_n_q  <= estof_n_d;
      wpt_n_q    <= wpt_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign EIPU_n   = eipu_n_q;
  assign EIPL_n   = eipl_n_q;
  assign EIPUR_n  = eipur_n_q;
  assign ESTOF_n  = estof_n_q;
  assign WPT_n    = wpt_n_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign ppn_hold = ppn_hold_q;

endmodule
